// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised up/down counter.
//   MODE_WRAP / MODE_SAT : encodings of the mode_sat input
//   DEF_WIDTH / DEF_PRESCALE_W : default counter and prescaler-select widths
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_PRESCALE_W = 4;

endpackage

// File: rtl/updown_counter_mod_if.sv
// Control/status bundle for updown_counter_mod.
//   master : the controller side; drives the controls and reads the status
//   slave  : the counter side; reads the controls and drives the status
// Controls: en, up, load, load_val, limit, mode_sat, prescale, clr_flags
// Status  : q, tc, ovf, unf, at_max, at_zero
interface updown_counter_mod_if
  import counter_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic [WIDTH-1:0]      limit;
  logic                  mode_sat;
  logic [PRESCALE_W-1:0] prescale;
  logic                  clr_flags;
  logic [WIDTH-1:0]      q;
  logic                  tc;
  logic                  ovf;
  logic                  unf;
  logic                  at_max;
  logic                  at_zero;

  modport master (
    output en, up, load, load_val, limit, mode_sat, prescale, clr_flags,
    input  q, tc, ovf, unf, at_max, at_zero
  );

  modport slave (
    input  en, up, load, load_val, limit, mode_sat, prescale, clr_flags,
    output q, tc, ovf, unf, at_max, at_zero
  );
endinterface

// File: rtl/count_prescaler.sv
// Clock-enable prescaler: produces one tick every (prescale+1) enabled cycles.
//   clk, rst : clock, asynchronous active-high reset
//   en       : advances the divider; no tick while low
//   clr      : restarts the divider from zero (takes priority over counting)
//   prescale : divide-minus-one
//   tick     : combinational, high on the enabled cycle that completes a period
module count_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt;

  // >= rather than == so that lowering prescale below the running count
  // ticks on the next enabled cycle instead of waiting for a wrap.
  assign tick = en & (pcnt >= prescale);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pcnt <= '0;
    else if (clr)  pcnt <= '0;
    else if (tick) pcnt <= '0;
    else if (en)   pcnt <= pcnt + 1'b1;
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with modulo limit, wrap/saturate mode,
// parallel load, prescaled count enable, terminal-count pulse and sticky
// overflow/underflow flags.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of updown_counter_mod_if (controls in, status out)
module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic              clk,
  input  logic              rst,
  updown_counter_mod_if.slave bus
);

  logic [WIDTH-1:0] q_r, q_nxt;
  logic             tc_r, tc_nxt;
  logic             ovf_r, unf_r;
  logic             ovf_set, unf_set;
  logic             tick, step;

  count_prescaler #(.PRESCALE_W(PRESCALE_W)) u_presc (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .clr      (bus.load),
    .prescale (bus.prescale),
    .tick     (tick)
  );

  assign step = tick & ~bus.load;

  always_comb begin
    q_nxt   = q_r;
    tc_nxt  = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (bus.load) begin
      q_nxt = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
    end else if (step) begin
      if (bus.up) begin
        if (q_r < bus.limit) begin
          q_nxt = q_r + 1'b1;
        end else begin
          q_nxt   = (bus.mode_sat == MODE_SAT) ? bus.limit : '0;
          tc_nxt  = 1'b1;
          ovf_set = 1'b1;
        end
      end else begin
        if (q_r == '0) begin
          q_nxt   = (bus.mode_sat == MODE_SAT) ? '0 : bus.limit;
          tc_nxt  = 1'b1;
          unf_set = 1'b1;
        end else if (q_r > bus.limit) begin
          // limit was lowered under a running count: pull back into range
          q_nxt = bus.limit;
        end else begin
          q_nxt = q_r - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r   <= '0;
      tc_r  <= 1'b0;
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      q_r   <= q_nxt;
      tc_r  <= tc_nxt;
      // a coincident boundary event beats clr_flags
      ovf_r <= ovf_set | (ovf_r & ~bus.clr_flags);
      unf_r <= unf_set | (unf_r & ~bus.clr_flags);
    end
  end

  assign bus.q       = q_r;
  assign bus.tc      = tc_r;
  assign bus.ovf     = ovf_r;
  assign bus.unf     = unf_r;
  assign bus.at_max  = (q_r == bus.limit);
  assign bus.at_zero = (q_r == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed testbench for updown_counter_mod (WIDTH=8, PRESCALE_W=4).
module tb_updown_counter_mod;
  import counter_pkg::*;

  localparam int W  = 8;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  updown_counter_mod_if #(.WIDTH(W), .PRESCALE_W(PW)) bus ();

  updown_counter_mod #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock, sample 1ns after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // directed vectors for the prescaler cadence
  logic       p_en [11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
  logic [7:0] p_q  [11] = '{10, 10, 11, 11, 11, 12, 12, 12, 12, 12, 13};
  logic [7:0] s_q  [4]  = '{1, 0, 0, 0};
  logic       s_tc [4]  = '{0, 0, 1, 1};

  initial begin
    bus.en = 0; bus.up = 1; bus.load = 0; bus.load_val = '0;
    bus.limit = 8'd5; bus.mode_sat = MODE_WRAP; bus.prescale = '0; bus.clr_flags = 0;
    #12;
    chk("rst_q", bus.q, 0);
    chk("rst_tc", bus.tc, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_unf", bus.unf, 0);
    chk("rst_at_zero", bus.at_zero, 1);
    cyc();
    rst = 0;

    // wrap up, limit 5
    bus.en = 1; bus.up = 1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      chk("wrap_q", bus.q, (i == 6) ? 0 : i);
      chk("wrap_tc", bus.tc, (i == 6) ? 1 : 0);
      chk("wrap_at_max", bus.at_max, (i == 5) ? 1 : 0);
    end
    chk("wrap_ovf", bus.ovf, 1);
    chk("wrap_unf", bus.unf, 0);
    bus.en = 0;
    cyc();
    chk("wrap_tc_drop", bus.tc, 0);

    // flag clear, then clear racing an overflow
    bus.clr_flags = 1;
    cyc();
    chk("clr_ovf", bus.ovf, 0);
    bus.clr_flags = 0; bus.load = 1; bus.load_val = 8'd5;
    cyc();
    chk("race_load_q", bus.q, 5);
    bus.load = 0; bus.en = 1; bus.clr_flags = 1;
    cyc();
    chk("race_q", bus.q, 0);
    chk("race_tc", bus.tc, 1);
    chk("race_ovf_set_wins", bus.ovf, 1);
    bus.en = 0;
    cyc();
    chk("race_clr_alone", bus.ovf, 0);
    chk("race_tc_drop", bus.tc, 0);
    bus.clr_flags = 0;

    // saturate down from 2
    bus.mode_sat = MODE_SAT; bus.load = 1; bus.load_val = 8'd2;
    cyc();
    chk("sat_load_q", bus.q, 2);
    bus.load = 0; bus.en = 1; bus.up = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("sat_q", bus.q, s_q[i]);
      chk("sat_tc", bus.tc, s_tc[i]);
    end
    chk("sat_unf", bus.unf, 1);
    bus.en = 0;

    // prescale=2, with a two-cycle enable gap
    bus.mode_sat = MODE_WRAP; bus.limit = 8'd100; bus.load = 1; bus.load_val = 8'd10;
    cyc();
    chk("pre_load_q", bus.q, 10);
    bus.load = 0; bus.prescale = 4'd2; bus.up = 1;
    for (int i = 0; i < 11; i++) begin
      bus.en = p_en[i];
      cyc();
      chk("pre_q", bus.q, p_q[i]);
    end

    // load restarts the prescaler
    bus.en = 1;
    cyc();
    chk("pclr_pre_q", bus.q, 13);
    bus.load = 1; bus.load_val = 8'd50;
    cyc();
    chk("pclr_load_q", bus.q, 50);
    bus.load = 0;
    cyc();
    chk("pclr_q1", bus.q, 50);
    cyc();
    chk("pclr_q2", bus.q, 50);
    cyc();
    chk("pclr_q3", bus.q, 51);

    // load beats a coincident tick, value clamped to limit
    cyc();
    chk("lvs_pre_q", bus.q, 51);
    bus.prescale = 4'd0; bus.load = 1; bus.load_val = 8'd200;
    cyc();
    chk("lvs_q", bus.q, 100);
    chk("lvs_tc", bus.tc, 0);
    chk("lvs_at_max", bus.at_max, 1);
    bus.load = 0; bus.up = 0;
    cyc();
    chk("lvs_down_q", bus.q, 99);

    // asynchronous reset mid-count
    bus.load = 1; bus.load_val = 8'h2A;
    cyc();
    chk("arst_pre_q", bus.q, 8'h2A);
    chk("arst_pre_unf", bus.unf, 1);
    bus.load = 0; bus.en = 0;
    #3;
    rst = 1;
    #1;
    chk("arst_q", bus.q, 0);
    chk("arst_unf", bus.unf, 0);
    chk("arst_ovf", bus.ovf, 0);
    chk("arst_tc", bus.tc, 0);
    cyc();
    chk("arst_hold_q", bus.q, 0);
    rst = 0;

    // limit=0: every step is a boundary
    bus.limit = 8'd0; bus.en = 1; bus.up = 1; bus.mode_sat = MODE_WRAP;
    cyc();
    chk("lim0_up_q", bus.q, 0);
    chk("lim0_up_tc", bus.tc, 1);
    chk("lim0_ovf", bus.ovf, 1);
    bus.up = 0; bus.mode_sat = MODE_SAT;
    cyc();
    chk("lim0_dn_q", bus.q, 0);
    chk("lim0_dn_tc", bus.tc, 1);
    chk("lim0_unf", bus.unf, 1);
    bus.en = 0;
    cyc();
    chk("lim0_tc_drop", bus.tc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000ns");
    $fatal(1);
  end

endmodule
